alu_operand_issue: RTL

Upstream issue stage for the processor-core ALU. It holds a 16-entry operand register file and accepts one instruction at a time over a valid/ready handshake. For each instruction it reads both source registers, drives alu_op/in1/in2, and waits a fixed ALU latency. It then writes alu_out back to the destination register and captures the ALU status word z.

---
 rtl/alu_operand_issue.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_operand_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_issue
// Purpose  : Issue stage in front of the core ALU. Holds a 2**REG_ADDR_W entry
//            operand register file and accepts one instruction at a time over
//            a valid/ready handshake. At the handshake both source operands and
//            the opcode are registered onto the ALU inputs. The block then
//            waits ALU_LAT cycles and writes alu_out back to the destination.
//            The ALU status word z is captured at the same edge.
// Ports    : clock, reset        - clock, asynchronous active-high reset
//            instr_valid/ready   - instruction handshake
//            instr_op/src1/src2/dst - opcode, source and destination regs
//            wr_en/wr_addr/wr_data  - external register load port
//            rd_addr/rd_data     - combinational debug read port
//            alu_op/in1/in2      - registered ALU inputs
//            alu_out, z          - ALU result and status word
//            z_last              - z captured at the last writeback
//            done                - one-cycle pulse per retired instruction
//            err_op              - sticky illegal-opcode flag (ops 4..7)
//            retired_cnt, busy_cycles - present only with ALU_ISSUE_PERF_EN
// Options  : `define ALU_ISSUE_PERF_EN adds the retired-instruction counter,
//            which wraps, and the saturating busy-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_issue #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int ALU_LAT    = 1     // legal range 1..7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [2:0]            instr_op,
    input  logic [REG_ADDR_W-1:0] instr_src1,
    input  logic [REG_ADDR_W-1:0] instr_src2,
    input  logic [REG_ADDR_W-1:0] instr_dst,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic [2:0]            alu_op,
    output logic [DATA_W-1:0]     in1,
    output logic [DATA_W-1:0]     in2,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic [DATA_W-1:0]     z,
    output logic [DATA_W-1:0]     z_last,
    output logic                  done,
    output logic                  err_op
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [15:0]           retired_cnt,
    output logic [15:0]           busy_cycles
`endif
);

    localparam int         c_NUM_REGS = 2 ** REG_ADDR_W;
    localparam logic [2:0] c_LAT      = 3'(ALU_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t                  r_state;
    logic [2:0]              r_cnt;
    logic [REG_ADDR_W-1:0]   r_dst;
    logic                    r_wb_en;     // latched: op is 1..3, so write back
    logic [DATA_W-1:0]       r_rf [c_NUM_REGS];

    logic                    w_handshake;
    logic                    w_op_legal;

    assign instr_ready = (r_state == S_IDLE) && !reset;
    assign w_handshake = instr_valid && instr_ready;
    assign w_op_legal  = !instr_op[2] && (instr_op != 3'd0);
    assign rd_data     = r_rf[rd_addr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dst   <= '0;
            r_wb_en <= 1'b0;
            alu_op  <= '0;
            in1     <= '0;
            in2     <= '0;
            z_last  <= '0;
            done    <= 1'b0;
            err_op  <= 1'b0;
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            done <= 1'b0;

            // External load first so that a same-cycle writeback below
            // overrides it for the same address.
            if (wr_en) begin
                r_rf[wr_addr] <= wr_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_handshake) begin
                        // Operands sampled here; the nonblocking read sees the
                        // pre-write contents even if wr_en targets a source.
                        in1     <= r_rf[instr_src1];
                        in2     <= r_rf[instr_src2];
                        alu_op  <= instr_op;
                        r_dst   <= instr_dst;
                        r_wb_en <= w_op_legal;
                        r_cnt   <= c_LAT;
                        r_state <= S_WAIT;
                        if (instr_op[2]) begin
                            err_op <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    if (r_wb_en) begin
                        r_rf[r_dst] <= alu_out;
                    end
                    z_last  <= z;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_cnt <= '0;
            busy_cycles <= '0;
        end else begin
            if (r_state == S_WB) begin
                retired_cnt <= retired_cnt + 16'd1;
            end
            if ((r_state != S_IDLE) && (busy_cycles != 16'hFFFF)) begin
                busy_cycles <= busy_cycles + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
